atm_session_ctrl: RTL and testbench

//  Front-end session controller sitting directly upstream of the ATM transaction core.

---
 rtl/atm_session_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// ATM session front end: card/PIN admission with lockout, single-request handshake to the
// transaction core, result/inventory reporting and idle-session timeout.
module atm_session_ctrl #(
  parameter int NUM_ACCOUNTS   = 15,
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        card_valid,
  input  logic [3:0]  card_acc,
  input  logic        pin_valid,
  input  logic [15:0] pin_in,
  output logic [3:0]  pin_rd_acc,
  input  logic [15:0] pin_rd_data,
  input  logic        op_valid,
  input  logic [1:0]  op_sel,
  input  logic [3:0]  op_dest,
  input  logic [9:0]  op_amount,
  output logic        core_req,
  output logic [1:0]  core_select,
  output logic [3:0]  core_origin,
  output logic [3:0]  core_purpose,
  output logic [9:0]  core_amount,
  input  logic        core_ack,
  input  logic [1:0]  core_result,
  input  logic [9:0]  core_inventory,
  output logic        status_valid,
  output logic [2:0]  status,
  output logic [9:0]  disp_inventory,
  output logic        session_active
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_PIN  = 3'd1;
  localparam logic [2:0] S_CHECK_PIN = 3'd2;
  localparam logic [2:0] S_MENU      = 3'd3;
  localparam logic [2:0] S_ISSUE     = 3'd4;
  localparam logic [2:0] S_WAIT_CORE = 3'd5;
  localparam logic [2:0] S_REPORT    = 3'd6;

  localparam logic [2:0] ST_EJECT    = 3'd0;
  localparam logic [2:0] ST_PIN_OK   = 3'd1;
  localparam logic [2:0] ST_PIN_BAD  = 3'd2;
  localparam logic [2:0] ST_LOCKED   = 3'd3;
  localparam logic [2:0] ST_OP_OK    = 3'd4;
  localparam logic [2:0] ST_OP_FAIL  = 3'd5;
  localparam logic [2:0] ST_TIMEOUT  = 3'd6;
  localparam logic [2:0] ST_BAD_ACCT = 3'd7;

  localparam int TRIES_W = $clog2(MAX_PIN_TRIES + 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]         ACC_LIMIT  = 4'(NUM_ACCOUNTS);
  localparam logic [TRIES_W-1:0] TRY_LAST   = TRIES_W'(MAX_PIN_TRIES - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]         r_state;
  logic [3:0]         r_acc;
  logic [15:0]        r_pin;
  logic [TRIES_W-1:0] r_tries;
  logic [15:0]        r_lock;
  logic [TIMER_W-1:0] r_timer;
  logic [1:0]         r_sel;
  logic [3:0]         r_dest;
  logic [9:0]         r_amount;
  logic               r_core_req;
  logic               r_status_valid;
  logic [2:0]         r_status;
  logic [9:0]         r_disp;
  logic               r_active;

  logic w_card_ok;
  logic w_card_locked;
  logic w_pin_match;
  logic w_dest_bad;
  logic w_amount_zero;
  logic w_timer_done;

  assign w_card_ok     = card_acc < ACC_LIMIT;
  assign w_card_locked = r_lock[card_acc];
  assign w_pin_match   = r_pin == pin_rd_data;
  assign w_dest_bad    = (op_dest >= ACC_LIMIT) || (op_dest == r_acc);
  assign w_amount_zero = op_amount == 10'd0;
  assign w_timer_done  = r_timer == TIMER_LAST;

  // User pulses that land while a status pulse is out are dropped, so status_valid
  // can never be high on two consecutive cycles.
  // NOTE: every register here uses non-blocking assignment so all state updates see
  // pre-edge values; the lock bits are plain flops and are cleared by reset with the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_pin          <= '0;
      r_tries        <= '0;
      r_lock         <= '0;
      r_timer        <= '0;
      r_sel          <= '0;
      r_dest         <= '0;
      r_amount       <= '0;
      r_core_req     <= 1'b0;
      r_status_valid <= 1'b0;
      r_status       <= '0;
      r_disp         <= '0;
      r_active       <= 1'b0;
    end else begin
      r_status_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (card_valid && !r_status_valid) begin
            if (!w_card_ok) begin
              r_status_valid <= 1'b1;
              r_status       <= ST_BAD_ACCT;
            end else if (w_card_locked) begin
              r_status_valid <= 1'b1;
              r_status       <= ST_LOCKED;
            end else begin
              r_acc   <= card_acc;
              r_tries <= '0;
              r_state <= S_WAIT_PIN;
            end
          end
        end
        S_WAIT_PIN: begin
          if (pin_valid) begin
            r_pin   <= pin_in;
            r_timer <= '0;
            r_state <= S_CHECK_PIN;
          end else if (w_timer_done) begin
            r_status_valid <= 1'b1;
            r_status       <= ST_TIMEOUT;
            r_active       <= 1'b0;
            r_disp         <= '0;
            r_timer        <= '0;
            r_state        <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_CHECK_PIN: begin
          r_timer        <= '0;
          r_status_valid <= 1'b1;
          if (w_pin_match) begin
            r_status <= ST_PIN_OK;
            r_tries  <= '0;
            r_active <= 1'b1;
            r_state  <= S_MENU;
          end else if (r_tries == TRY_LAST) begin
            r_lock[r_acc] <= 1'b1;
            r_status      <= ST_LOCKED;
            r_tries       <= '0;
            r_active      <= 1'b0;
            r_disp        <= '0;
            r_state       <= S_IDLE;
          end else begin
            r_tries  <= r_tries + 1'b1;
            r_status <= ST_PIN_BAD;
            r_state  <= S_WAIT_PIN;
          end
        end
        S_MENU: begin
          if (op_valid && !r_status_valid) begin
            r_timer <= '0;
            if (op_sel == 2'd0) begin
              r_status_valid <= 1'b1;
              r_status       <= ST_EJECT;
              r_active       <= 1'b0;
              r_disp         <= '0;
              r_state        <= S_IDLE;
            end else if (op_sel == 2'd3 && w_dest_bad) begin
              r_status_valid <= 1'b1;
              r_status       <= ST_BAD_ACCT;
            end else if (op_sel[1] && w_amount_zero) begin
              r_status_valid <= 1'b1;
              r_status       <= ST_OP_FAIL;
            end else begin
              r_sel    <= op_sel;
              r_dest   <= op_dest;
              r_amount <= op_amount;
              r_state  <= S_ISSUE;
            end
          end else if (w_timer_done) begin
            r_status_valid <= 1'b1;
            r_status       <= ST_TIMEOUT;
            r_active       <= 1'b0;
            r_disp         <= '0;
            r_timer        <= '0;
            r_state        <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_ISSUE: begin
          r_core_req <= 1'b1;
          r_state    <= S_WAIT_CORE;
        end
        S_WAIT_CORE: begin
          if (core_ack) begin
            r_core_req     <= 1'b0;
            r_status_valid <= 1'b1;
            r_status       <= (core_result == 2'd3) ? ST_OP_OK : ST_OP_FAIL;
            if (r_sel == 2'd1) r_disp <= core_inventory;
            r_state        <= S_REPORT;
          end
        end
        S_REPORT: begin
          r_state <= S_MENU;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pin_rd_acc     = r_acc;
  assign core_req       = r_core_req;
  assign core_select    = r_sel;
  assign core_origin    = r_acc;
  assign core_purpose   = r_dest;
  assign core_amount    = r_amount;
  assign status_valid   = r_status_valid;
  assign status         = r_status;
  assign disp_inventory = r_disp;
  assign session_active = r_active;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: PIN table model (PIN of account n is 16'h1000+n),
// hand-computed expectations checked with immediate assertions after each clock edge.
module tb_atm_session_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        card_valid = 1'b0;
  logic [3:0]  card_acc = '0;
  logic        pin_valid = 1'b0;
  logic [15:0] pin_in = '0;
  logic [3:0]  pin_rd_acc;
  logic [15:0] pin_rd_data;
  logic        op_valid = 1'b0;
  logic [1:0]  op_sel = '0;
  logic [3:0]  op_dest = '0;
  logic [9:0]  op_amount = '0;
  logic        core_req;
  logic [1:0]  core_select;
  logic [3:0]  core_origin;
  logic [3:0]  core_purpose;
  logic [9:0]  core_amount;
  logic        core_ack = 1'b0;
  logic [1:0]  core_result = '0;
  logic [9:0]  core_inventory = '0;
  logic        status_valid;
  logic [2:0]  status;
  logic [9:0]  disp_inventory;
  logic        session_active;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign pin_rd_data = 16'h1000 + {12'h000, pin_rd_acc};

  atm_session_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .card_valid     (card_valid),
    .card_acc       (card_acc),
    .pin_valid      (pin_valid),
    .pin_in         (pin_in),
    .pin_rd_acc     (pin_rd_acc),
    .pin_rd_data    (pin_rd_data),
    .op_valid       (op_valid),
    .op_sel         (op_sel),
    .op_dest        (op_dest),
    .op_amount      (op_amount),
    .core_req       (core_req),
    .core_select    (core_select),
    .core_origin    (core_origin),
    .core_purpose   (core_purpose),
    .core_amount    (core_amount),
    .core_ack       (core_ack),
    .core_result    (core_result),
    .core_inventory (core_inventory),
    .status_valid   (status_valid),
    .status         (status),
    .disp_inventory (disp_inventory),
    .session_active (session_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_card(input logic [3:0] acc);
    card_valid = 1'b1;
    card_acc   = acc;
    step();
    card_valid = 1'b0;
  endtask

  task automatic pulse_pin(input logic [15:0] pin);
    pin_valid = 1'b1;
    pin_in    = pin;
    step();
    pin_valid = 1'b0;
  endtask

  task automatic pulse_op(input logic [1:0] sel, input logic [3:0] dest, input logic [9:0] amt);
    op_valid  = 1'b1;
    op_sel    = sel;
    op_dest   = dest;
    op_amount = amt;
    step();
    op_valid  = 1'b0;
  endtask

  task automatic pulse_ack(input logic [1:0] res, input logic [9:0] inv);
    core_ack       = 1'b1;
    core_result    = res;
    core_inventory = inv;
    step();
    core_ack       = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_status_valid", status_valid, 1'b0);
    check("rst_status", status, 3'd0);
    check("rst_active", session_active, 1'b0);
    check("rst_core_req", core_req, 1'b0);
    check("rst_disp", disp_inventory, 10'd0);
    check("rst_pin_rd_acc", pin_rd_acc, 4'd0);
    rst_n = 1'b1;
    step();

    // Card 4 with the correct PIN
    pulse_card(4'd4);
    check("card4_no_status", status_valid, 1'b0);
    check("card4_rd_acc", pin_rd_acc, 4'd4);
    pulse_pin(16'h1004);
    check("pin_checking_no_status", status_valid, 1'b0);
    step();
    check("pin_ok_valid", status_valid, 1'b1);
    check("pin_ok_status", status, 3'd1);
    check("pin_ok_active", session_active, 1'b1);
    step();
    check("pin_ok_single_pulse", status_valid, 1'b0);

    // Display, inventory 100
    pulse_op(2'd1, 4'd0, 10'd0);
    check("disp_issue_no_req", core_req, 1'b0);
    step();
    check("disp_req", core_req, 1'b1);
    check("disp_select", core_select, 2'd1);
    check("disp_origin", core_origin, 4'd4);
    repeat (2) step();
    check("disp_req_held", core_req, 1'b1);
    pulse_ack(2'd3, 10'd100);
    check("disp_req_dropped", core_req, 1'b0);
    check("disp_status_valid", status_valid, 1'b1);
    check("disp_status", status, 3'd4);
    check("disp_inventory", disp_inventory, 10'd100);
    step();
    check("disp_report_one_cycle", status_valid, 1'b0);
    check("disp_still_active", session_active, 1'b1);

    // Withdraw 150, insufficient funds
    pulse_op(2'd2, 4'd0, 10'd150);
    step();
    check("wd_req", core_req, 1'b1);
    check("wd_amount", core_amount, 10'd150);
    check("wd_select", core_select, 2'd2);
    repeat (3) step();
    check("wd_req_held", core_req, 1'b1);
    check("wd_amount_stable", core_amount, 10'd150);
    pulse_ack(2'd1, 10'd555);
    check("wd_req_dropped", core_req, 1'b0);
    check("wd_status", status, 3'd5);
    check("wd_status_valid", status_valid, 1'b1);
    check("wd_disp_unchanged", disp_inventory, 10'd100);
    step();

    // Transfer to invalid / own account, and zero-amount withdraw
    pulse_op(2'd3, 4'd15, 10'd10);
    check("xfer15_valid", status_valid, 1'b1);
    check("xfer15_status", status, 3'd7);
    step();
    check("xfer15_no_req", core_req, 1'b0);
    pulse_op(2'd3, 4'd4, 10'd10);
    check("xfer_own_status", status, 3'd7);
    check("xfer_own_valid", status_valid, 1'b1);
    step();
    check("xfer_own_no_req", core_req, 1'b0);
    pulse_op(2'd2, 4'd0, 10'd0);
    check("wd_zero_status", status, 3'd5);
    check("wd_zero_valid", status_valid, 1'b1);

    // Idle timeout: expiry 1000 edges after the last accepted input
    repeat (999) step();
    check("pre_timeout_active", session_active, 1'b1);
    check("pre_timeout_no_status", status_valid, 1'b0);
    step();
    check("timeout_valid", status_valid, 1'b1);
    check("timeout_status", status, 3'd6);
    check("timeout_active", session_active, 1'b0);
    check("timeout_disp_cleared", disp_inventory, 10'd0);
    step();

    // Three wrong PINs lock account 4
    pulse_card(4'd4);
    pulse_pin(16'h9999);
    step();
    check("bad1_status", status, 3'd2);
    check("bad1_valid", status_valid, 1'b1);
    pulse_pin(16'h9999);
    step();
    check("bad2_status", status, 3'd2);
    pulse_pin(16'h9999);
    step();
    check("bad3_status", status, 3'd3);
    check("bad3_valid", status_valid, 1'b1);
    check("bad3_inactive", session_active, 1'b0);
    step();
    pulse_card(4'd4);
    check("locked_valid", status_valid, 1'b1);
    check("locked_status", status, 3'd3);
    step();
    pulse_pin(16'h1004);
    step();
    check("locked_stays_idle", status_valid, 1'b0);
    pulse_card(4'd15);
    check("bad_acct_status", status, 3'd7);
    check("bad_acct_valid", status_valid, 1'b1);
    step();

    // Reset while waiting on the core
    pulse_card(4'd5);
    pulse_pin(16'h1005);
    step();
    check("acc5_pin_ok", status, 3'd1);
    step();
    pulse_card(4'd15);
    check("card_ignored_in_menu", status_valid, 1'b0);
    pulse_op(2'd2, 4'd0, 10'd20);
    step();
    check("rst_mid_req_up", core_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", core_req, 1'b0);
    check("async_rst_active", session_active, 1'b0);
    repeat (2) step();
    check("async_rst_no_status", status_valid, 1'b0);
    rst_n = 1'b1;
    step();
    pulse_card(4'd4);
    check("lock_cleared_no_status", status_valid, 1'b0);
    check("lock_cleared_rd_acc", pin_rd_acc, 4'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
